// File: rtl/exec_pkg.sv
// exec_pkg
//   Shared encodings for the execute stage: ALU operation codes,
//   result-source select codes and the multiplier FSM state type.
//   Imported by exec_stage_param and seq_multiplier.
package exec_pkg;

    // ALU operation select (ALUop). Codes not listed here produce 0.
    localparam logic [3:0] OP_AND  = 4'd0;
    localparam logic [3:0] OP_OR   = 4'd1;
    localparam logic [3:0] OP_ADD  = 4'd2;
    localparam logic [3:0] OP_SLTU = 4'd4;
    localparam logic [3:0] OP_SUB  = 4'd6;
    localparam logic [3:0] OP_SLT  = 4'd7;
    localparam logic [3:0] OP_MUL  = 4'd8;

    // Result bus source select (ResSource). Code 3 is reserved and selects 0.
    localparam logic [1:0] SRC_ALU   = 2'd0;
    localparam logic [1:0] SRC_SHIFT = 2'd1;
    localparam logic [1:0] SRC_MULHI = 2'd2;

    // Iterative multiplier sequencing.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } mulState_t;

endpackage

// File: rtl/exec_stage_param_mul.sv
// seq_multiplier
//   Unsigned shift-add multiplier that retires one multiplier bit per cycle.
//   A Start pulse in IDLE captures A and B; ITERS cycles in BUSY accumulate
//   the product; one DONE cycle presents the finished product.
// Ports
//   CLK     rising-edge clock
//   Reset   asynchronous active-high reset
//   Start   begin a multiply (honoured only in IDLE)
//   A, B    operands, sampled on the Start edge
//   Busy    high in BUSY and DONE
//   Done    high for the single DONE cycle
//   ProdLo  lower WIDTH bits of the accumulator
//   ProdHi  upper WIDTH bits of the accumulator
module seq_multiplier
    import exec_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int ITERS = WIDTH
) (
    input  logic             CLK,
    input  logic             Reset,
    input  logic             Start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             Busy,
    output logic             Done,
    output logic [WIDTH-1:0] ProdLo,
    output logic [WIDTH-1:0] ProdHi
);

    localparam int CNT_W = (ITERS > 1) ? $clog2(ITERS) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(ITERS - 1);

    mulState_t          state;
    logic [CNT_W-1:0]   count;
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] mcand;
    logic [WIDTH-1:0]   mplier;

    // The multiplicand shifts left and the multiplier shifts right each
    // iteration, so testing mplier[0] and adding mcand is the same as
    // testing B[count] and adding A << count.
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            state  <= ST_IDLE;
            count  <= '0;
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (Start) begin
                        mcand  <= {{WIDTH{1'b0}}, A};
                        mplier <= B;
                        acc    <= '0;
                        count  <= '0;
                        state  <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    if (mplier[0]) begin
                        acc <= acc + mcand;
                    end
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    count  <= count + 1'b1;
                    if (count == LAST) begin
                        state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign Busy   = (state != ST_IDLE);
    assign Done   = (state == ST_DONE);
    assign ProdLo = acc[WIDTH-1:0];
    assign ProdHi = acc[2*WIDTH-1:WIDTH];

endmodule

// File: rtl/exec_stage_param.sv
// exec_stage_param
//   Execute stage with result register. Combinational ALU (AND, OR, ADD,
//   SLTU, SUB, SLT), iterative unsigned multiply with pipeline stall, and a
//   high-product register that can be routed onto the result bus.
// Ports
//   CLK         rising-edge clock
//   Reset       asynchronous active-high reset
//   ALUInA/B    operands
//   ShifterOut  shifter result, bypasses the ALU
//   ALUop       operation select (exec_pkg OP_*)
//   ResSource   result bus select (exec_pkg SRC_*)
//   ResWrite    load the result register
//   ExValid     operands and control valid
//   ResOut      registered result
//   isZero      ALU result of the present inputs is zero
//   Stall       multiply in progress, upstream holds inputs
//   MulHi       upper half of the last product
module exec_stage_param
    import exec_pkg::*;
#(
    parameter int WIDTH      = 16,
    parameter int MUL_CYCLES = WIDTH
) (
    input  logic             CLK,
    input  logic             Reset,
    input  logic [WIDTH-1:0] ALUInA,
    input  logic [WIDTH-1:0] ALUInB,
    input  logic [WIDTH-1:0] ShifterOut,
    input  logic [3:0]       ALUop,
    input  logic [1:0]       ResSource,
    input  logic             ResWrite,
    input  logic             ExValid,
    output logic [WIDTH-1:0] ResOut,
    output logic             isZero,
    output logic             Stall,
    output logic [WIDTH-1:0] MulHi
);

    logic [WIDTH-1:0] aluResult;
    logic [WIDTH-1:0] resultMux;
    logic [WIDTH-1:0] prodLo;
    logic [WIDTH-1:0] prodHi;
    logic             mulBusy;
    logic             mulDone;
    logic             mulStart;
    logic             mulBlock;
    logic             resWriteLatched;

    // MUL deliberately yields 0 here; its result arrives via the multiplier.
    always_comb begin
        aluResult = '0;
        case (ALUop)
            OP_AND:  aluResult = ALUInA & ALUInB;
            OP_OR:   aluResult = ALUInA | ALUInB;
            OP_ADD:  aluResult = ALUInA + ALUInB;
            OP_SLTU: aluResult[0] = (ALUInA < ALUInB);
            OP_SUB:  aluResult = ALUInA - ALUInB;
            OP_SLT:  aluResult[0] = ($signed(ALUInA) < $signed(ALUInB));
            OP_MUL:  aluResult = '0;
            default: aluResult = '0;
        endcase
    end

    assign isZero = (aluResult == '0);

    always_comb begin
        resultMux = '0;
        case (ResSource)
            SRC_ALU:   resultMux = aluResult;
            SRC_SHIFT: resultMux = ShifterOut;
            SRC_MULHI: resultMux = MulHi;
            default:   resultMux = '0;
        endcase
    end

    // mulBlock stops inputs still held after a multiply from starting
    // another one; it clears once ExValid drops or the op changes.
    assign mulStart = ExValid && (ALUop == OP_MUL) && !mulBusy && !mulBlock;

    seq_multiplier #(
        .WIDTH (WIDTH),
        .ITERS (MUL_CYCLES)
    ) u_mul (
        .CLK    (CLK),
        .Reset  (Reset),
        .Start  (mulStart),
        .A      (ALUInA),
        .B      (ALUInB),
        .Busy   (mulBusy),
        .Done   (mulDone),
        .ProdLo (prodLo),
        .ProdHi (prodHi)
    );

    assign Stall = mulBusy;

    // The DONE cycle owns the result register; otherwise only single-cycle
    // ops in an idle stage may write it.
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            ResOut          <= '0;
            MulHi           <= '0;
            resWriteLatched <= 1'b0;
            mulBlock        <= 1'b0;
        end else begin
            if (mulStart) begin
                resWriteLatched <= ResWrite;
            end

            if (mulDone) begin
                MulHi <= prodHi;
                if (resWriteLatched) begin
                    ResOut <= prodLo;
                end
            end else if (!mulBusy && ExValid && ResWrite && (ALUop != OP_MUL)) begin
                ResOut <= resultMux;
            end

            if (mulDone) begin
                mulBlock <= 1'b1;
            end else if (!ExValid || (ALUop != OP_MUL)) begin
                mulBlock <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_exec_stage_param.sv
// tb_exec_stage_param
//   Directed bench for exec_stage_param at WIDTH = 16 and WIDTH = 8.
//   Both instances share operand buses; each has its own ExValid so only
//   one is active at a time.
module tb_exec_stage_param;
    import exec_pkg::*;

    logic        CLK = 1'b0;
    logic        Reset;
    logic [3:0]  aluOp;
    logic [15:0] inA;
    logic [15:0] inB;
    logic [15:0] shiftIn;
    logic [1:0]  resSource;
    logic        resWrite;
    logic        valid16;
    logic        valid8;

    logic [15:0] resOut16;
    logic [15:0] mulHi16;
    logic        isZero16;
    logic        stall16;
    logic [7:0]  resOut8;
    logic [7:0]  mulHi8;
    logic        isZero8;
    logic        stall8;

    int checks = 0;
    int errors = 0;
    int stallCycles;

    always #5 CLK = ~CLK;

    exec_stage_param #(.WIDTH(16)) dut16 (
        .CLK        (CLK),
        .Reset      (Reset),
        .ALUInA     (inA),
        .ALUInB     (inB),
        .ShifterOut (shiftIn),
        .ALUop      (aluOp),
        .ResSource  (resSource),
        .ResWrite   (resWrite),
        .ExValid    (valid16),
        .ResOut     (resOut16),
        .isZero     (isZero16),
        .Stall      (stall16),
        .MulHi      (mulHi16)
    );

    exec_stage_param #(.WIDTH(8)) dut8 (
        .CLK        (CLK),
        .Reset      (Reset),
        .ALUInA     (inA[7:0]),
        .ALUInB     (inB[7:0]),
        .ShifterOut (shiftIn[7:0]),
        .ALUop      (aluOp),
        .ResSource  (resSource),
        .ResWrite   (resWrite),
        .ExValid    (valid8),
        .ResOut     (resOut8),
        .isZero     (isZero8),
        .Stall      (stall8),
        .MulHi      (mulHi8)
    );

    // Drive inputs at the falling edge, let one rising edge consume them,
    // and return at the next falling edge where outputs are settled.
    task automatic applyStimulus(input logic [3:0] op, input logic [15:0] a,
                                 input logic [15:0] b, input logic [15:0] sh,
                                 input logic [1:0] src, input logic wr,
                                 input logic vld, input logic to8);
        aluOp     = op;
        inA       = a;
        inB       = b;
        shiftIn   = sh;
        resSource = src;
        resWrite  = wr;
        valid16   = vld & ~to8;
        valid8    = vld & to8;
        @(posedge CLK);
        @(negedge CLK);
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Called right after the accepting edge; counts falling edges with
    // Stall high and returns once Stall drops, bounded to 40 cycles.
    task automatic measureStall(input bit use8, output int n);
        n = 0;
        for (int i = 0; i < 40; i++) begin
            if (use8 ? stall8 : stall16) begin
                n++;
            end else if (n > 0) begin
                break;
            end
            @(posedge CLK);
            @(negedge CLK);
        end
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: observed timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        Reset     = 1'b1;
        aluOp     = OP_AND;
        inA       = '0;
        inB       = '0;
        shiftIn   = '0;
        resSource = SRC_ALU;
        resWrite  = 1'b0;
        valid16   = 1'b0;
        valid8    = 1'b0;
        @(negedge CLK);
        checkOutput("rst_res16",   32'(resOut16), 32'h0);
        checkOutput("rst_hi16",    32'(mulHi16),  32'h0);
        checkOutput("rst_stall16", 32'(stall16),  32'h0);
        checkOutput("rst_res8",    32'(resOut8),  32'h0);
        Reset = 1'b0;

        // Logic and arithmetic stream, 16-bit
        applyStimulus(OP_AND, 16'h0005, 16'hFFFC, 16'h0, SRC_ALU, 1'b1, 1'b1, 1'b0);
        checkOutput("and_res",  32'(resOut16), 32'h0004);
        checkOutput("and_zero", 32'(isZero16), 32'h0);
        applyStimulus(OP_OR, 16'h0005, 16'hFFFC, 16'h0, SRC_ALU, 1'b1, 1'b1, 1'b0);
        checkOutput("or_res",  32'(resOut16), 32'hFFFD);
        checkOutput("or_zero", 32'(isZero16), 32'h0);
        applyStimulus(OP_ADD, 16'h0005, 16'hFFFC, 16'h0, SRC_ALU, 1'b1, 1'b1, 1'b0);
        checkOutput("add_res",  32'(resOut16), 32'h0001);
        checkOutput("add_zero", 32'(isZero16), 32'h0);
        applyStimulus(OP_SLT, 16'h0005, 16'hFFFC, 16'h0, SRC_ALU, 1'b1, 1'b1, 1'b0);
        checkOutput("slt_res", 32'(resOut16), 32'h0000);
        applyStimulus(OP_SUB, 16'h0005, 16'hFFFC, 16'h0, SRC_ALU, 1'b1, 1'b1, 1'b0);
        checkOutput("sub_res", 32'(resOut16), 32'h0009);
        applyStimulus(4'hF, 16'h0005, 16'hFFFC, 16'h0, SRC_ALU, 1'b1, 1'b1, 1'b0);
        checkOutput("undef_res",  32'(resOut16), 32'h0000);
        checkOutput("undef_zero", 32'(isZero16), 32'h1);
        applyStimulus(OP_SLTU, 16'h0005, 16'hFFFC, 16'h0, SRC_ALU, 1'b1, 1'b1, 1'b0);
        checkOutput("sltu_res", 32'(resOut16), 32'h0001);
        applyStimulus(OP_SUB, 16'h1234, 16'h1234, 16'h0, SRC_ALU, 1'b1, 1'b1, 1'b0);
        checkOutput("subz_res",  32'(resOut16), 32'h0000);
        checkOutput("subz_zero", 32'(isZero16), 32'h1);

        // Shifter bypass and hold behaviour
        applyStimulus(OP_ADD, 16'h0001, 16'h0001, 16'hA5A5, SRC_SHIFT, 1'b1, 1'b1, 1'b0);
        checkOutput("shift_res", 32'(resOut16), 32'hA5A5);
        applyStimulus(OP_ADD, 16'h0001, 16'h0001, 16'h5A5A, SRC_SHIFT, 1'b0, 1'b1, 1'b0);
        checkOutput("hold_wr0", 32'(resOut16), 32'hA5A5);
        applyStimulus(OP_ADD, 16'h0001, 16'h0001, 16'h1111, SRC_SHIFT, 1'b1, 1'b0, 1'b0);
        checkOutput("hold_vld0", 32'(resOut16), 32'hA5A5);

        // MUL 0xFFFF x 0xFFFF with write; inputs stay held throughout
        applyStimulus(OP_MUL, 16'hFFFF, 16'hFFFF, 16'h0, SRC_ALU, 1'b1, 1'b1, 1'b0);
        checkOutput("mul_zero", 32'(isZero16), 32'h1);
        measureStall(1'b0, stallCycles);
        checkOutput("mul1_stall", 32'(stallCycles), 32'd17);
        checkOutput("mul1_lo",    32'(resOut16),    32'h0001);
        checkOutput("mul1_hi",    32'(mulHi16),     32'hFFFE);
        applyStimulus(OP_MUL, 16'hFFFF, 16'hFFFF, 16'h0, SRC_ALU, 1'b1, 1'b1, 1'b0);
        checkOutput("mul1_noretrig", 32'(stall16),  32'h0);
        checkOutput("mul1_keep",     32'(resOut16), 32'h0001);

        // MUL 0x12 x 0x34 without write, then MFHI
        applyStimulus(OP_ADD, 16'h0, 16'h0, 16'h0, SRC_ALU, 1'b0, 1'b0, 1'b0);
        applyStimulus(OP_MUL, 16'h0012, 16'h0034, 16'h0, SRC_ALU, 1'b0, 1'b1, 1'b0);
        measureStall(1'b0, stallCycles);
        checkOutput("mul2_stall", 32'(stallCycles), 32'd17);
        checkOutput("mul2_keep",  32'(resOut16),    32'h0001);
        checkOutput("mul2_hi",    32'(mulHi16),     32'h0000);
        applyStimulus(OP_ADD, 16'h0001, 16'h0002, 16'h0, SRC_MULHI, 1'b1, 1'b1, 1'b0);
        checkOutput("mfhi0_res", 32'(resOut16), 32'h0000);

        // MUL 0x1234 x 0x5678 = 0x06260060, then MFHI of a nonzero high half
        applyStimulus(OP_MUL, 16'h1234, 16'h5678, 16'h0, SRC_ALU, 1'b1, 1'b1, 1'b0);
        measureStall(1'b0, stallCycles);
        checkOutput("mul3_lo", 32'(resOut16), 32'h0060);
        checkOutput("mul3_hi", 32'(mulHi16),  32'h0626);
        applyStimulus(OP_ADD, 16'h0, 16'h0, 16'h0, SRC_ALU, 1'b0, 1'b0, 1'b0);
        applyStimulus(OP_ADD, 16'h0001, 16'h0002, 16'h0, SRC_MULHI, 1'b1, 1'b1, 1'b0);
        checkOutput("mfhi_res", 32'(resOut16), 32'h0626);

        // Reset five cycles into a MUL
        applyStimulus(OP_MUL, 16'hFFFF, 16'hFFFF, 16'h0, SRC_ALU, 1'b1, 1'b1, 1'b0);
        repeat (4) begin
            @(posedge CLK);
            @(negedge CLK);
        end
        checkOutput("pre_rst_stall", 32'(stall16), 32'h1);
        Reset = 1'b1;
        #1;
        checkOutput("arst_res",   32'(resOut16), 32'h0);
        checkOutput("arst_hi",    32'(mulHi16),  32'h0);
        checkOutput("arst_stall", 32'(stall16),  32'h0);
        @(negedge CLK);
        Reset = 1'b0;
        applyStimulus(OP_ADD, 16'h0002, 16'h0003, 16'h0, SRC_ALU, 1'b1, 1'b1, 1'b0);
        checkOutput("post_rst_add",   32'(resOut16), 32'h0005);
        checkOutput("post_rst_stall", 32'(stall16),  32'h0);

        // WIDTH = 8 instance
        applyStimulus(OP_AND, 16'h0005, 16'h00FC, 16'h0, SRC_ALU, 1'b1, 1'b1, 1'b1);
        checkOutput("w8_and", 32'(resOut8), 32'h04);
        applyStimulus(OP_OR, 16'h0005, 16'h00FC, 16'h0, SRC_ALU, 1'b1, 1'b1, 1'b1);
        checkOutput("w8_or", 32'(resOut8), 32'hFD);
        applyStimulus(OP_ADD, 16'h0005, 16'h00FC, 16'h0, SRC_ALU, 1'b1, 1'b1, 1'b1);
        checkOutput("w8_add",  32'(resOut8), 32'h01);
        checkOutput("w8_zero", 32'(isZero8), 32'h0);
        applyStimulus(OP_MUL, 16'h00FF, 16'h00FF, 16'h0, SRC_ALU, 1'b1, 1'b1, 1'b1);
        measureStall(1'b1, stallCycles);
        checkOutput("w8_mul_stall", 32'(stallCycles), 32'd9);
        checkOutput("w8_mul_lo",    32'(resOut8),     32'h01);
        checkOutput("w8_mul_hi",    32'(mulHi8),      32'hFE);
        checkOutput("w8_idle16",    32'(resOut16),    32'h0005);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
